// File: rtl/bit_adder_64.sv
// -----------------------------------------------------------------------------
// bit_adder_64
//   Integer add datapath for the execute stage (ADD/ADDI, address calculation).
//   A ripple chain of one-bit full-adder cells computes a + b + cin
//   combinationally. The result is captured into an output register so the
//   ripple chain is never part of a downstream timing path.
//
// Parameters
//   WIDTH      operand/sum width in bits (any WIDTH >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears sum/cout/out_valid
//   in_valid   a/b/cin are valid this cycle and are captured on the rising edge
//   a, b       operands (unsigned; two's-complement add is bit-identical)
//   cin        carry into bit 0
//   sum        registered (a + b + cin) mod 2^WIDTH
//   cout       registered carry out of bit WIDTH-1
//   out_valid  sum/cout hold a result captured from an in_valid cycle
// -----------------------------------------------------------------------------
module bit_adder_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_next_s;
    logic             cout_next_s;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             out_valid_r;

    // Each cell keeps its own carry-in/carry-out nets rather than sharing one
    // carry vector, so the chain is seen as a straight sequence of separate
    // signals instead of one vector that feeds back into itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic c_in_s;
        logic c_out_s;
        logic p_s;

        if (i == 0) begin : g_first
            assign c_in_s = cin;
        end else begin : g_chain
            assign c_in_s = g_cell[i-1].c_out_s;
        end

        // Propagate term is shared between the sum bit and the carry.
        assign p_s           = a[i] ^ b[i];
        assign sum_next_s[i] = p_s ^ c_in_s;
        assign c_out_s       = (a[i] & b[i]) | (c_in_s & p_s);
    end

    assign cout_next_s = g_cell[WIDTH-1].c_out_s;

    // Output register: capture on in_valid, otherwise hold the data and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            sum_r       <= sum_next_s;
            cout_r      <= cout_next_s;
            out_valid_r <= 1'b1;
        end else begin
            // Operands are not looked at here, so X on a/b/cin cannot leak in.
            sum_r       <= sum_r;
            cout_r      <= cout_r;
            out_valid_r <= 1'b0;
        end
    end

    assign sum       = sum_r;
    assign cout      = cout_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_bit_adder_64.sv
module tb_bit_adder_64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    bit_adder_64 #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors with hand-computed results.
    localparam int NV = 5;
    logic [63:0] va   [NV];
    logic [63:0] vb   [NV];
    logic        vcin [NV];
    logic [63:0] vsum [NV];
    logic        vcout[NV];

    initial begin
        va[0] = 64'h5;                   vb[0] = 64'hA;                   vcin[0] = 1'b0;
        vsum[0] = 64'hF;                 vcout[0] = 1'b0;
        va[1] = 64'hFF;                  vb[1] = 64'h1;                   vcin[1] = 1'b1;
        vsum[1] = 64'h101;               vcout[1] = 1'b0;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'h1;                   vcin[2] = 1'b0;
        vsum[2] = 64'h0;                 vcout[2] = 1'b1;
        va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'hFFFF_FFFF_FFFF_FFFF; vcin[3] = 1'b1;
        vsum[3] = 64'hFFFF_FFFF_FFFF_FFFF; vcout[3] = 1'b1;
        va[4] = 64'h1234_5678_90AB_CDEF; vb[4] = 64'hFEDC_BA09_8765_4321; vcin[4] = 1'b0;
        vsum[4] = 64'h1111_1082_1811_1110; vcout[4] = 1'b1;
    end

    task automatic drive(input logic v, input logic [63:0] ta, input logic [63:0] tb_,
                         input logic tc);
        in_valid = v;
        a        = ta;
        b        = tb_;
        cin      = tc;
    endtask

    task automatic test_reset;
        // Load a non-zero result first so the reset clear is observable.
        @(posedge clk); #1;
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        n_checks++;
        if (sum !== 64'h1 || cout !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload: got sum=%h cout=%b ov=%b want sum=1 cout=1 ov=1",
                     sum, cout, out_valid);
        end
        // Assert reset between edges: must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (sum !== 64'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got sum=%h cout=%b ov=%b want 0/0/0",
                     sum, cout, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // With in_valid low the outputs must stay at zero.
        @(posedge clk); #1;
        n_checks++;
        if (sum !== 64'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stay: got sum=%h cout=%b ov=%b want 0/0/0",
                     sum, cout, out_valid);
        end
    endtask

    task automatic test_vectors;
        for (int k = 0; k < NV; k++) begin
            drive(1'b1, va[k], vb[k], vcin[k]);
            @(posedge clk); #1;
            drive(1'b0, 64'h0, 64'h0, 1'b0);
            n_checks++;
            if (sum !== vsum[k] || cout !== vcout[k] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL vector_%0d: got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=1",
                         k, sum, cout, out_valid, vsum[k], vcout[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, va[0], vb[0], vcin[0]);
        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            if (k + 1 < NV) drive(1'b1, va[k+1], vb[k+1], vcin[k+1]);
            else            drive(1'b0, 64'h0, 64'h0, 1'b0);
            n_checks++;
            if (sum !== vsum[k] || cout !== vcout[k] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=1",
                         k, sum, cout, out_valid, vsum[k], vcout[k]);
            end
        end
        // Idle with X-ish operands: result held, valid drops.
        a = 'x; b = 'x; cin = 1'bx;
        @(posedge clk); #1;
        n_checks++;
        if (sum !== vsum[NV-1] || cout !== vcout[NV-1] || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=0",
                     sum, cout, out_valid, vsum[NV-1], vcout[NV-1]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (sum !== vsum[NV-1] || cout !== vcout[NV-1] || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold2: got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=0",
                     sum, cout, out_valid, vsum[NV-1], vcout[NV-1]);
        end
        drive(1'b0, 64'h0, 64'h0, 1'b0);
    endtask

    task automatic test_reset_mid;
        // Capture pending at the next edge, but reset lands first.
        drive(1'b1, 64'h5, 64'hA, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (sum !== 64'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got sum=%h cout=%b ov=%b want 0/0/0",
                     sum, cout, out_valid);
        end
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (sum !== 64'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_lost: got sum=%h cout=%b ov=%b want 0/0/0",
                     sum, cout, out_valid);
        end
    endtask

    task automatic test_random;
        logic [64:0] model;
        logic [63:0] exp_sum  = sum;
        logic        exp_cout = cout;
        logic        exp_ov;
        logic        v;
        logic [63:0] ra, rb;
        logic        rc;
        for (int k = 0; k < 10000; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = $urandom_range(0, 1) == 1;
            if (k % 97 == 0) rb = ~ra;  // long carry propagate
            drive(v, ra, rb, rc);
            if (v) begin
                model    = {1'b0, ra} + {1'b0, rb} + {64'h0, rc};
                exp_sum  = model[63:0];
                exp_cout = model[64];
            end
            exp_ov = v;
            @(posedge clk); #1;
            n_checks++;
            if (sum !== exp_sum || cout !== exp_cout || out_valid !== exp_ov) begin
                n_fail++;
                $display("FAIL random_%0d: got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=%b",
                         k, sum, cout, out_valid, exp_sum, exp_cout, exp_ov);
            end
        end
        drive(1'b0, 64'h0, 64'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        #1;
        n_checks++;
        if (sum !== 64'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: got sum=%h cout=%b ov=%b want 0/0/0",
                     sum, cout, out_valid);
        end
        #10 rst_n = 1'b1;
        test_reset;
        test_vectors;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
